eight_to_three_encoder: RTL and testbench

EIGHT_TO_THREE_ENCODER -- requirements
Module: eight_to_three_encoder

---
 rtl/eight_to_three_encoder_pkg.sv | 27 ++
 rtl/eight_to_three_encoder_prio_enc8.sv | 15 +
 rtl/eight_to_three_encoder.sv | 95 +++++++++
 tb/tb_eight_to_three_encoder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/eight_to_three_encoder_pkg.sv
// Shared types, widths and the priority-encode function for the request encoder.
package eight_to_three_encoder_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } stateT;

  // Later hits overwrite earlier ones, so the scan order sets the priority.
  function automatic logic [CODE_W-1:0] prioEncode(input logic [N_REQ-1:0] req,
                                                   input logic highFirst);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (highFirst) begin
        if (req[i]) idx = CODE_W'(i);
      end else begin
        if (req[N_REQ-1-i]) idx = CODE_W'(N_REQ-1-i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/eight_to_three_encoder_prio_enc8.sv
// Combinational priority winner select over eight request lines, plus an any-bit flag.
module prio_enc8
  import eight_to_three_encoder_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [N_REQ-1:0]  i_req,
  output logic [CODE_W-1:0] o_idx,
  output logic              o_any
);

  assign o_idx = prioEncode(i_req, HIGH_FIRST);
  assign o_any = |i_req;

endmodule

// File: rtl/eight_to_three_encoder.sv
// Pending-request encoder with valid/ready handshake driving a 3-to-8 decoder select.
// Optional sticky overflow flag enabled by defining ENC_OVERFLOW_FLAG_EN.
module eight_to_three_encoder
  import eight_to_three_encoder_pkg::*;
#(
  parameter int HIGH_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] d,
  input  logic             ready,
  output logic             s2,
  output logic             s1,
  output logic             s0,
  output logic             valid,
  output logic [N_REQ-1:0] pending
`ifdef ENC_OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  stateT             r_state;
  stateT             w_stateNext;
  logic [CODE_W-1:0] r_code;
  logic [CODE_W-1:0] w_codeNext;
  logic [N_REQ-1:0]  r_pending;
  logic [N_REQ-1:0]  w_pendingNext;
  logic [N_REQ-1:0]  w_clearMask;
  logic [CODE_W-1:0] w_winner;
  logic              w_any;
  logic              w_load;

  prio_enc8 #(
    .HIGH_FIRST (HIGH_FIRST != 0)
  ) u_prio (
    .i_req (r_pending),
    .o_idx (w_winner),
    .o_any (w_any)
  );

  // A new code is loaded from IDLE, or from HOLD once the consumer takes the current one.
  always_comb begin
    w_stateNext = r_state;
    w_codeNext  = r_code;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_load      = 1'b1;
          w_stateNext = HOLD;
        end
      end
      HOLD: begin
        if (ready) begin
          if (w_any) w_load = 1'b1;
          else       w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
    if (w_load) w_codeNext = w_winner;
    w_clearMask   = w_load ? (N_REQ'(1) << w_winner) : '0;
    w_pendingNext = (r_pending & ~w_clearMask) | d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_code    <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_code    <= w_codeNext;
      r_pending <= w_pendingNext;
    end
  end

`ifdef ENC_OVERFLOW_FLAG_EN
  logic r_ovf;

  // Sticky: a request that lands on an already-pending bit is merged and so lost.
  always_ff @(posedge clk) begin
    if (rst)                    r_ovf <= 1'b0;
    else if (|(r_pending & d))  r_ovf <= 1'b1;
  end

  assign ovf = r_ovf;
`endif

  assign {s2, s1, s0} = r_code;
  assign valid        = (r_state == HOLD);
  assign pending      = r_pending;

endmodule

// File: tb/tb_eight_to_three_encoder.sv
// Directed, table-driven bench for eight_to_three_encoder (HIGH_FIRST=1).
module tb_eight_to_three_encoder;

  typedef struct {
    logic       rst;
    logic [7:0] d;
    logic       ready;
    logic       expValid;
    logic       checkCode;
    logic [2:0] expCode;
    logic [7:0] expPending;
    logic       checkOvf;
    logic       expOvf;
  } vecT;

  localparam int NV = 29;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic       ready;
  logic       s2, s1, s0;
  logic       valid;
  logic [7:0] pending;
`ifdef ENC_OVERFLOW_FLAG_EN
  logic       ovf;
`endif

  int checks   = 0;
  int failures = 0;
  vecT table_v [NV];

  eight_to_three_encoder #(
    .HIGH_FIRST (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .ready   (ready),
    .s2      (s2),
    .s1      (s1),
    .s0      (s0),
    .valid   (valid),
    .pending (pending)
`ifdef ENC_OVERFLOW_FLAG_EN
    ,
    .ovf     (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vecT mk(input logic r, input logic [7:0] dv, input logic rd,
                             input logic ev, input logic [2:0] ec, input logic [7:0] ep);
    vecT v;
    v.rst        = r;
    v.d          = dv;
    v.ready      = rd;
    v.expValid   = ev;
    v.checkCode  = ev | r;
    v.expCode    = ec;
    v.expPending = ep;
    v.checkOvf   = 1'b0;
    v.expOvf     = 1'b0;
    return v;
  endfunction

  task automatic checkOutput(input vecT v, input string name);
    logic [2:0] code;
    logic [7:0] decoded;
    logic [7:0] expDecoded;
    code = {s2, s1, s0};
    checks++;
    if (valid !== v.expValid) begin
      failures++;
      $display("[TB] FAIL %s valid: got %b expected %b", name, valid, v.expValid);
    end
    checks++;
    if (pending !== v.expPending) begin
      failures++;
      $display("[TB] FAIL %s pending: got %b expected %b", name, pending, v.expPending);
    end
    if (v.checkCode) begin
      checks++;
      if (code !== v.expCode) begin
        failures++;
        $display("[TB] FAIL %s code: got %b expected %b", name, code, v.expCode);
      end
    end
    if (v.expValid) begin
      decoded    = 8'b1 << code;
      expDecoded = 8'b1 << v.expCode;
      checks++;
      if (decoded !== expDecoded) begin
        failures++;
        $display("[TB] FAIL %s decoder: got %b expected %b", name, decoded, expDecoded);
      end
    end
`ifdef ENC_OVERFLOW_FLAG_EN
    if (v.checkOvf) begin
      checks++;
      if (ovf !== v.expOvf) begin
        failures++;
        $display("[TB] FAIL %s ovf: got %b expected %b", name, ovf, v.expOvf);
      end
    end
`endif
  endtask

  // Inputs are held for one clock; outputs are sampled 1 time unit after the edge.
  task automatic applyStimulus(input vecT v, input string name);
    rst   = v.rst;
    d     = v.d;
    ready = v.ready;
    @(posedge clk);
    #1;
    checkOutput(v, name);
  endtask

  initial begin
    vecT v;
    rst   = 1'b1;
    d     = 8'h00;
    ready = 1'b0;

    // Reset with d active (ignored), then single pulse on bit 2.
    table_v[0]  = mk(1, 8'hFF, 0, 0, 3'd0, 8'h00);
    table_v[1]  = mk(0, 8'h04, 1, 0, 3'd0, 8'h04);
    table_v[2]  = mk(0, 8'h00, 1, 1, 3'd2, 8'h00);
    table_v[3]  = mk(0, 8'h00, 1, 0, 3'd0, 8'h00);
    // Bits 7 and 0 together: 111 then 000 back to back.
    table_v[4]  = mk(0, 8'h81, 1, 0, 3'd0, 8'h81);
    table_v[5]  = mk(0, 8'h00, 1, 1, 3'd7, 8'h01);
    table_v[6]  = mk(0, 8'h00, 1, 1, 3'd0, 8'h00);
    table_v[7]  = mk(0, 8'h00, 1, 0, 3'd0, 8'h00);
    // All eight bits: descending codes on eight consecutive cycles.
    table_v[8]  = mk(0, 8'hFF, 1, 0, 3'd0, 8'hFF);
    table_v[9]  = mk(0, 8'h00, 1, 1, 3'd7, 8'h7F);
    table_v[10] = mk(0, 8'h00, 1, 1, 3'd6, 8'h3F);
    table_v[11] = mk(0, 8'h00, 1, 1, 3'd5, 8'h1F);
    table_v[12] = mk(0, 8'h00, 1, 1, 3'd4, 8'h0F);
    table_v[13] = mk(0, 8'h00, 1, 1, 3'd3, 8'h07);
    table_v[14] = mk(0, 8'h00, 1, 1, 3'd2, 8'h03);
    table_v[15] = mk(0, 8'h00, 1, 1, 3'd1, 8'h01);
    table_v[16] = mk(0, 8'h00, 1, 1, 3'd0, 8'h00);
    table_v[17] = mk(0, 8'h00, 1, 0, 3'd0, 8'h00);
    // Re-request of the held code, and arrival on the same edge it is cleared.
    table_v[18] = mk(0, 8'h10, 0, 0, 3'd0, 8'h10);
    table_v[19] = mk(0, 8'h00, 0, 1, 3'd4, 8'h00);
    table_v[20] = mk(0, 8'h10, 0, 1, 3'd4, 8'h10);
    table_v[21] = mk(0, 8'h10, 1, 1, 3'd4, 8'h10);
    table_v[22] = mk(0, 8'h00, 1, 1, 3'd4, 8'h00);
    table_v[23] = mk(0, 8'h00, 1, 0, 3'd0, 8'h00);
    // Repeated request for a pending bit merges into a single issue.
    table_v[24] = mk(0, 8'h80, 0, 0, 3'd0, 8'h80);
    table_v[25] = mk(0, 8'h02, 0, 1, 3'd7, 8'h02);
    table_v[26] = mk(0, 8'h02, 0, 1, 3'd7, 8'h02);
    table_v[27] = mk(0, 8'h00, 1, 1, 3'd1, 8'h00);
    table_v[28] = mk(0, 8'h00, 1, 0, 3'd0, 8'h00);

    for (int i = 0; i < NV; i++) begin
      applyStimulus(table_v[i], $sformatf("vec%0d", i));
    end

    // Held code 101 with ready low while bit 6 arrives; then 110 follows.
    applyStimulus(mk(0, 8'h20, 0, 0, 3'd0, 8'h00 | 8'h20), "stall_load");
    applyStimulus(mk(0, 8'h00, 0, 1, 3'd5, 8'h00), "stall_c0");
    applyStimulus(mk(0, 8'h40, 0, 1, 3'd5, 8'h40), "stall_c1");
    for (int i = 2; i < 5; i++) begin
      applyStimulus(mk(0, 8'h00, 0, 1, 3'd5, 8'h40), $sformatf("stall_c%0d", i));
    end
    applyStimulus(mk(0, 8'h00, 1, 1, 3'd6, 8'h00), "stall_next");
    applyStimulus(mk(0, 8'h00, 1, 0, 3'd0, 8'h00), "stall_idle");

    // Reset mid-HOLD with bits 5 and 4 still pending.
    applyStimulus(mk(0, 8'h70, 0, 0, 3'd0, 8'h70), "rst_load");
    applyStimulus(mk(0, 8'h00, 0, 1, 3'd6, 8'h30), "rst_hold");
    applyStimulus(mk(1, 8'h08, 1, 0, 3'd0, 8'h00), "rst_pulse");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mk(0, 8'h00, 1, 0, 3'd0, 8'h00), $sformatf("rst_after%0d", i));
    end

`ifdef ENC_OVERFLOW_FLAG_EN
    // Bit 3 requested twice while pending behind a stalled code 111.
    v = mk(0, 8'h80, 0, 0, 3'd0, 8'h80); v.checkOvf = 1; v.expOvf = 0;
    applyStimulus(v, "ovf_a");
    v = mk(0, 8'h00, 0, 1, 3'd7, 8'h00); v.checkOvf = 1; v.expOvf = 0;
    applyStimulus(v, "ovf_b");
    v = mk(0, 8'h08, 0, 1, 3'd7, 8'h08); v.checkOvf = 1; v.expOvf = 0;
    applyStimulus(v, "ovf_first");
    v = mk(0, 8'h08, 0, 1, 3'd7, 8'h08); v.checkOvf = 1; v.expOvf = 1;
    applyStimulus(v, "ovf_second");
    v = mk(0, 8'h00, 1, 1, 3'd3, 8'h00); v.checkOvf = 1; v.expOvf = 1;
    applyStimulus(v, "ovf_issue");
    for (int i = 0; i < 3; i++) begin
      v = mk(0, 8'h00, 1, 0, 3'd0, 8'h00); v.checkOvf = 1; v.expOvf = 1;
      applyStimulus(v, $sformatf("ovf_sticky%0d", i));
    end
    v = mk(1, 8'h00, 0, 0, 3'd0, 8'h00); v.checkOvf = 1; v.expOvf = 0;
    applyStimulus(v, "ovf_rst");
`else
    v = mk(0, 8'h00, 0, 0, 3'd0, 8'h00);
    applyStimulus(v, "final_idle");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
